// File: rtl/audio_pkg.sv
// Shared definitions for the audio metering blocks: peak FSM encodings,
// saturating decay and LED bar thresholds.
package audio_pkg;

  localparam logic [1:0] ST_TRACK = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_FALL  = 2'd2;

  // Saturating subtract: decays toward zero and never wraps.
  function automatic int unsigned sat_sub(input int unsigned x, input int unsigned step);
    return (x >= step) ? x - step : 32'd0;
  endfunction

  // Threshold of bar segment k for a full scale of 2^width-1 split over count segments.
  function automatic int unsigned led_thr(input int unsigned k, input int unsigned width,
                                          input int unsigned count);
    return ((k + 32'd1) * ((32'd1 << width) - 32'd1)) / count;
  endfunction

endpackage

// File: rtl/audio_tick_gen.sv
// Free-running prescaler: one-cycle tick every DECAY_TICKS clocks, first tick
// DECAY_TICKS cycles after reset release.
module audio_tick_gen #(
  parameter int DECAY_TICKS = 100000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (DECAY_TICKS > 1) ? $clog2(DECAY_TICKS) : 1;

  logic [CW-1:0] count;

  assign tick = (count == CW'(DECAY_TICKS - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/audio_level_meter.sv
// Fast-attack / linear-decay level meter with peak hold and an LED bar
// (thermometer bar OR'd with a one-hot peak dot).
module audio_level_meter
  import audio_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 8,
  parameter int LED_COUNT    = 8,
  parameter int DECAY_TICKS  = 100000,
  parameter int DECAY_STEP   = 4,
  parameter int HOLD_STEPS   = 50
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SAMPLE_WIDTH-1:0] sample_i,
  input  logic                    sample_valid_i,
  output logic [SAMPLE_WIDTH-1:0] level_o,
  output logic [SAMPLE_WIDTH-1:0] peak_o,
  output logic [LED_COUNT-1:0]    leds_o
);

  localparam int HW = $clog2(HOLD_STEPS + 1);

  logic                    tick;
  logic [SAMPLE_WIDTH-1:0] cand;
  logic [SAMPLE_WIDTH-1:0] level_next;
  logic [SAMPLE_WIDTH-1:0] peak_dec;
  logic [1:0]              state;
  logic [HW-1:0]           hold_cnt;
  logic [LED_COUNT-1:0]    bar;
  logic [LED_COUNT-1:0]    dot;

  audio_tick_gen #(
    .DECAY_TICKS(DECAY_TICKS)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  // A tick and a sample on the same cycle resolve to the larger of the two.
  always_comb begin
    cand       = tick ? SAMPLE_WIDTH'(sat_sub(32'(level_o), DECAY_STEP)) : level_o;
    level_next = (sample_valid_i && (sample_i > cand)) ? sample_i : cand;
    peak_dec   = SAMPLE_WIDTH'(sat_sub(32'(peak_o), DECAY_STEP));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_o  <= '0;
      peak_o   <= '0;
      state    <= ST_TRACK;
      hold_cnt <= '0;
    end else begin
      level_o <= level_next;
      // A new maximum restarts the hold from any state and outranks the tick.
      if (sample_valid_i && (sample_i > peak_o)) begin
        peak_o   <= sample_i;
        hold_cnt <= HW'(HOLD_STEPS);
        state    <= ST_HOLD;
      end else begin
        case (state)
          ST_TRACK: peak_o <= level_next;
          ST_HOLD: begin
            if (tick) begin
              hold_cnt <= hold_cnt - 1'b1;
              if (hold_cnt == HW'(1)) state <= ST_FALL;
            end
          end
          ST_FALL: begin
            if (tick) begin
              if (peak_dec <= level_next) begin
                peak_o <= level_next;
                state  <= ST_TRACK;
              end else begin
                peak_o <= peak_dec;
              end
            end
          end
          default: state <= ST_TRACK;
        endcase
      end
    end
  end

  // NOTE: bar and dot get a full default before the loop so no latch is inferred.
  always_comb begin
    bar = '0;
    dot = '0;
    for (int k = 0; k < LED_COUNT; k++) begin
      bar[k] = (32'(level_o) >= led_thr(k, SAMPLE_WIDTH, LED_COUNT));
      if (32'(peak_o) >= led_thr(k, SAMPLE_WIDTH, LED_COUNT)) begin
        dot    = '0;
        dot[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      leds_o <= '0;
    end else begin
      leds_o <= bar | dot;
    end
  end

endmodule
